// File: rtl/uart_tx_word_feeder.sv
// uart_tx_word_feeder
//   Buffers multi-byte words in a small circular FIFO and serializes each word
//   into bytes for a UART transmitter. Bytes are released one per out_ready.
//
// Ports
//   CLK        system clock, rising edge
//   reset      synchronous, active-high reset
//   in_data    word to transmit (WORD_BYTES*8 bits)
//   in_valid   in_data is valid
//   in_ready   FIFO can accept a word this cycle
//   out_data   byte presented to the transmitter
//   out_valid  out_data is valid (registered)
//   out_ready  transmitter can accept a byte
//   level      words held in the FIFO, excluding the word in the serializer
module uart_tx_word_feeder #(
   parameter int unsigned WORD_BYTES = 4,
   parameter int unsigned DEPTH      = 8,
   parameter bit          MSB_FIRST  = 1'b0
) (
   input  logic                      CLK,
   input  logic                      reset,
   input  logic [WORD_BYTES*8-1:0]   in_data,
   input  logic                      in_valid,
   output logic                      in_ready,
   output logic [7:0]                out_data,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [$clog2(DEPTH):0]    level
);

   localparam int unsigned W  = WORD_BYTES * 8;
   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned IW = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;

   typedef enum logic {IDLE, SEND} state_t;

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wptr;
   logic [AW-1:0] rptr;
   state_t        state;
   logic [W-1:0]  shreg;
   logic [IW-1:0] idx;
   logic          push;
   logic          pop;
   logic          last_byte;

   assign in_ready  = (level != (AW+1)'(DEPTH));
   assign push      = in_valid && in_ready;
   assign last_byte = (idx == IW'(WORD_BYTES - 1));

   // The output byte always sits at the end of the shift register that the
   // shift moves toward, so out_data is a fixed slice of a register.
   assign out_data = MSB_FIRST ? shreg[W-1 -: 8] : shreg[7:0];

   // Pop whenever the serializer loads: from IDLE with data waiting, or on the
   // last byte's handshake when another word is already queued (no bubble).
   always_comb begin
      pop = 1'b0;
      if (state == IDLE) begin
         pop = (level != '0);
      end else begin
         pop = out_ready && last_byte && (level != '0);
      end
   end

   always_ff @(posedge CLK) begin
      if (push) begin
         mem[wptr] <= in_data;
      end
   end

   always_ff @(posedge CLK) begin
      if (reset) begin
         wptr      <= '0;
         rptr      <= '0;
         level     <= '0;
         state     <= IDLE;
         shreg     <= '0;
         idx       <= '0;
         out_valid <= 1'b0;
      end else begin
         if (push) begin
            wptr <= wptr + 1'b1;
         end
         if (pop) begin
            rptr <= rptr + 1'b1;
         end
         level <= level + (AW+1)'(push) - (AW+1)'(pop);

         if (state == IDLE) begin
            if (pop) begin
               shreg     <= mem[rptr];
               idx       <= '0;
               state     <= SEND;
               out_valid <= 1'b1;
            end
         end else if (out_ready) begin
            if (!last_byte) begin
               shreg <= MSB_FIRST ? (shreg << 8) : (shreg >> 8);
               idx   <= idx + 1'b1;
            end else if (pop) begin
               shreg <= mem[rptr];
               idx   <= '0;
            end else begin
               idx       <= '0;
               state     <= IDLE;
               out_valid <= 1'b0;
            end
         end
      end
   end

endmodule
